// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding muxes, ALU, branch resolution and the EX/MEM output register.
// Define EX_MULDIV_EN to build the iterative shift-add MUL (op 12) with its BUSY state.
module ex_stage_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_alu_op,
    input  logic            in_alu_src,
    input  logic            in_branch,
    input  logic            in_mem_read,
    input  logic            in_mem_to_reg,
    input  logic            in_reg_write,
    input  logic [1:0]      in_mem_write,
    input  logic            fwd_mem_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_br_taken,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [1:0]      out_mem_write,
    output logic            out_mem_read,
    output logic            out_mem_to_reg,
    output logic            out_reg_write
);

    localparam int SHW = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] br_target;
        logic            br_taken;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [1:0]      mem_write;
        logic            mem_read;
        logic            mem_to_reg;
        logic            reg_write;
    } ctrl_t;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res;
    logic [SHW-1:0]  sh;
    logic            br_cond, accept, idle, is_mul;
    ctrl_t           cur_ctrl;

    // MEM stage is younger than WB, so its match takes priority; x0 never forwards.
    always_comb begin
        rs1_fwd = in_rs1_data;
        if (fwd_mem_we && fwd_mem_rd == in_rs1 && in_rs1 != 5'd0)
            rs1_fwd = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == in_rs1 && in_rs1 != 5'd0)
            rs1_fwd = fwd_wb_data;
        rs2_fwd = in_rs2_data;
        if (fwd_mem_we && fwd_mem_rd == in_rs2 && in_rs2 != 5'd0)
            rs2_fwd = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == in_rs2 && in_rs2 != 5'd0)
            rs2_fwd = fwd_wb_data;
        op_a = rs1_fwd;
        op_b = in_alu_src ? in_imm : rs2_fwd;
        sh   = op_b[SHW-1:0];
    end

    always_comb begin
        alu_res = '0;
        case (in_alu_op)
            5'd0:  alu_res = op_a + op_b;
            5'd1:  alu_res = op_a - op_b;
            5'd2:  alu_res = op_a << sh;
            5'd3:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            5'd4:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            5'd5:  alu_res = op_a ^ op_b;
            5'd6:  alu_res = op_a >> sh;
            5'd7:  alu_res = $signed(op_a) >>> sh;
            5'd8:  alu_res = op_a | op_b;
            5'd9:  alu_res = op_a & op_b;
            5'd10: alu_res = op_b;
            5'd11: alu_res = in_pc + op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (in_funct3)
            3'b000:  br_cond = (rs1_fwd == rs2_fwd);
            3'b001:  br_cond = (rs1_fwd != rs2_fwd);
            3'b100:  br_cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
            3'b101:  br_cond = !($signed(rs1_fwd) < $signed(rs2_fwd));
            3'b110:  br_cond = (rs1_fwd < rs2_fwd);
            3'b111:  br_cond = !(rs1_fwd < rs2_fwd);
            default: br_cond = 1'b0;
        endcase
        cur_ctrl.store_data = rs2_fwd;
        cur_ctrl.br_target  = in_pc + in_imm;
        cur_ctrl.br_taken   = in_branch && br_cond;
        cur_ctrl.rd         = in_rd;
        cur_ctrl.funct3     = in_funct3;
        cur_ctrl.mem_write  = in_mem_write;
        cur_ctrl.mem_read   = in_mem_read;
        cur_ctrl.mem_to_reg = in_mem_to_reg;
        cur_ctrl.reg_write  = in_reg_write;
    end

    logic            valid_q, valid_d;
    logic [XLEN-1:0] res_q, res_d;
    ctrl_t           out_q, out_d;

    assign in_ready = idle && (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef EX_MULDIV_EN
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d, step;
    ctrl_t           pend_q, pend_d;
    logic            mul_done;

    assign is_mul = (in_alu_op == 5'd12);
    assign idle   = (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        pend_d   = pend_q;
        mul_done = 1'b0;
        step     = acc_q + (mplr_q[0] ? mcand_q : '0);
        if (state_q == S_IDLE) begin
            if (accept && is_mul) begin
                state_d = S_BUSY;
                cnt_d   = '0;
                mcand_d = op_a;
                mplr_d  = op_b;
                acc_d   = '0;
                pend_d  = cur_ctrl;
            end
        end else begin
            acc_d   = step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            // Last of XLEN steps: step already holds the full low-half product.
            if (cnt_q == CW'(XLEN - 1)) begin
                mul_done = 1'b1;
                state_d  = S_IDLE;
                cnt_d    = '0;
            end
        end
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            mul_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
        end
    end
`else
    assign is_mul = 1'b0;
    assign idle   = 1'b1;
`endif

    always_comb begin
        out_d   = out_q;
        res_d   = res_q;
        valid_d = valid_q && !out_ready;
        if (accept && !is_mul) begin
            out_d   = cur_ctrl;
            res_d   = alu_res;
            valid_d = 1'b1;
        end
`ifdef EX_MULDIV_EN
        if (mul_done) begin
            out_d   = pend_q;
            res_d   = step;
            valid_d = 1'b1;
        end
`endif
        if (flush)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_alu_result = res_q;
    assign out_store_data = out_q.store_data;
    assign out_br_target  = out_q.br_target;
    assign out_br_taken   = out_q.br_taken;
    assign out_rd         = out_q.rd;
    assign out_funct3     = out_q.funct3;
    assign out_mem_write  = out_q.mem_write;
    assign out_mem_read   = out_q.mem_read;
    assign out_mem_to_reg = out_q.mem_to_reg;
    assign out_reg_write  = out_q.reg_write;

endmodule
